// File: rtl/axi_package_writer_pkg.sv
// -----------------------------------------------------------------------------
// axi_package_writer_pkg
// Shared definitions for the AXI package writer: FSM state encoding, AXI burst
// and response constants, and a small unsigned-minimum helper used when sizing
// each burst.
// -----------------------------------------------------------------------------
package axi_package_writer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_RESP = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// pop_data whenever empty is low; pop consumes it. A push while full or a pop
// while empty is ignored. Simultaneous push and pop leave count unchanged.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write side
//   pop, pop_data   read side (pop_data valid while !empty)
//   count           number of stored entries (0..DEPTH)
//   full, empty     status flags derived from count
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          do_push,  do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem[rd_ptr_q];

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;

        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; emptiness is tracked
    // by the pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/axi_package_writer.sv
// -----------------------------------------------------------------------------
// axi_package_writer
// Streams TOTAL_PACKAGE beats from a valid/ready input into AXI4 INCR write
// bursts of up to DATA_DEPTH beats, starting at a byte address sampled on
// write_start. Each burst is fully buffered in the FIFO before its address
// phase, so the W channel never starves mid-burst.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   write_start, axi_awaddr_start  run start pulse and base byte address
//   in_data, in_valid, in_ready    input beat stream
//   axi_aw*                        write address channel (INCR, fixed size)
//   axi_w*                         write data channel (data from FIFO head)
//   axi_b*                         write response channel
//   write_done                     run finished (held until next start/rst)
//   write_error                    sticky: a non-OKAY response was seen
// -----------------------------------------------------------------------------
module axi_package_writer
    import axi_package_writer_pkg::*;
#(
    parameter int TOTAL_PACKAGE   = 400,
    parameter int DATA_DEPTH      = 16,
    parameter int DATA_BYTE_SHIFT = 5,
    parameter int DATA_BYTE_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         write_start,
    input  logic [31:0]                  axi_awaddr_start,
    input  logic [DATA_BYTE_WIDTH*8-1:0] in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [31:0]                  axi_awaddr,
    output logic [7:0]                   axi_awlen,
    output logic [2:0]                   axi_awsize,
    output logic [1:0]                   axi_awburst,
    output logic                         axi_awvalid,
    input  logic                         axi_awready,
    output logic [DATA_BYTE_WIDTH*8-1:0] axi_wdata,
    output logic                         axi_wlast,
    output logic                         axi_wvalid,
    input  logic                         axi_wready,
    input  logic [1:0]                   axi_bresp,
    input  logic                         axi_bvalid,
    output logic                         axi_bready,
    output logic                         write_done,
    output logic                         write_error
);

    localparam int DW = DATA_BYTE_WIDTH * 8;
    localparam int CW = $clog2(DATA_DEPTH + 1);
    localparam logic [31:0] DEPTH32 = 32'(DATA_DEPTH);
    localparam logic [31:0] TOTAL32 = 32'(TOTAL_PACKAGE);

    state_e      state_q,     state_d;
    logic [31:0] remaining_q, remaining_d;
    logic [31:0] addr_q,      addr_d;
    logic [7:0]  awlen_q,     awlen_d;
    logic [7:0]  beat_q,      beat_d;
    logic        done_q,      done_d;
    logic        error_q,     error_d;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic          run_active;
    logic [31:0]   burst_len;
    logic [31:0]   cur_len;

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (DATA_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (axi_wdata),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign run_active = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign in_ready   = run_active && !fifo_full;
    assign fifo_push  = in_valid && in_ready;

    // Length of the burst being assembled (FILL) and of the burst in flight.
    assign burst_len = min_u32(remaining_q, DEPTH32);
    assign cur_len   = 32'(awlen_q) + 32'd1;

    assign axi_awaddr  = addr_q;
    assign axi_awlen   = awlen_q;
    assign axi_awsize  = 3'(DATA_BYTE_SHIFT);
    assign axi_awburst = AXI_BURST_INCR;
    assign write_done  = done_q;
    assign write_error = error_q;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        awlen_d     = awlen_q;
        beat_d      = beat_q;
        done_d      = done_q;
        error_d     = error_q;
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_wlast   = 1'b0;
        axi_bready  = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (write_start) begin
                    state_d     = ST_FILL;
                    remaining_d = TOTAL32;
                    addr_d      = axi_awaddr_start;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                end
            end

            // Wait until the whole burst is buffered; this guarantees W never
            // underruns once the address has been issued.
            ST_FILL: begin
                if (32'(fifo_count) >= burst_len) begin
                    awlen_d = 8'(burst_len - 32'd1);
                    beat_d  = '0;
                    state_d = ST_ADDR;
                end
            end

            ST_ADDR: begin
                axi_awvalid = 1'b1;
                if (axi_awready) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                axi_wvalid = !fifo_empty;
                axi_wlast  = axi_wvalid && (beat_q == awlen_q);
                if (axi_wvalid && axi_wready) begin
                    fifo_pop = 1'b1;
                    beat_d   = beat_q + 8'd1;
                    if (axi_wlast) begin
                        state_d = ST_RESP;
                    end
                end
            end

            ST_RESP: begin
                axi_bready = 1'b1;
                if (axi_bvalid) begin
                    if (axi_bresp != AXI_RESP_OKAY) begin
                        error_d = 1'b1;
                    end
                    addr_d      = addr_q + (cur_len << DATA_BYTE_SHIFT);
                    remaining_d = remaining_q - cur_len;
                    if (remaining_q == cur_len) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            awlen_q     <= '0;
            beat_q      <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            awlen_q     <= awlen_d;
            beat_q      <= beat_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_axi_package_writer.sv
// -----------------------------------------------------------------------------
// tb_axi_package_writer
// Directed bench: a 400-beat instance driven by a stallable AXI slave model and
// input source, plus a 20-beat instance for the partial-final-burst case.
// Inputs change on the falling edge; handshakes are logged on that same edge
// for the rising edge that follows.
// -----------------------------------------------------------------------------
module tb_axi_package_writer;

    localparam int DW    = 256;
    localparam int TOTAL = 400;
    localparam int NB    = 25;
    localparam logic [31:0] BURST_BYTES = 32'd512;

    int checks   = 0;
    int failures = 0;

    logic clk;
    logic rst;

    // 400-beat instance
    logic          write_start;
    logic [31:0]   awaddr_start;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready;
    logic [31:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic          wlast, wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;
    logic          write_done, write_error;

    // 20-beat instance
    logic          s_write_start;
    logic [31:0]   s_awaddr_start;
    logic [DW-1:0] s_in_data;
    logic          s_in_valid, s_in_ready;
    logic [31:0]   s_awaddr;
    logic [7:0]    s_awlen;
    logic [2:0]    s_awsize;
    logic [1:0]    s_awburst;
    logic          s_awvalid, s_awready;
    logic [DW-1:0] s_wdata;
    logic          s_wlast, s_wvalid, s_wready;
    logic [1:0]    s_bresp;
    logic          s_bvalid, s_bready;
    logic          s_write_done, s_write_error;

    axi_package_writer dut (
        .clk(clk), .rst(rst), .write_start(write_start), .axi_awaddr_start(awaddr_start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst),
        .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wlast(wlast), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .write_done(write_done), .write_error(write_error)
    );

    axi_package_writer #(.TOTAL_PACKAGE(20)) dut_s (
        .clk(clk), .rst(rst), .write_start(s_write_start), .axi_awaddr_start(s_awaddr_start),
        .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .axi_awaddr(s_awaddr), .axi_awlen(s_awlen), .axi_awsize(s_awsize), .axi_awburst(s_awburst),
        .axi_awvalid(s_awvalid), .axi_awready(s_awready),
        .axi_wdata(s_wdata), .axi_wlast(s_wlast), .axi_wvalid(s_wvalid), .axi_wready(s_wready),
        .axi_bresp(s_bresp), .axi_bvalid(s_bvalid), .axi_bready(s_bready),
        .write_done(s_write_done), .write_error(s_write_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave / source model state for the 400-beat instance
    int  aw_stall, w_stall, b_stall, in_pct, err_burst;
    int  src_val, beat_cnt, b_idx, overlap, wlast_err, err_seen, err_dropped;
    int  cur_len;
    bit  b_pending;
    logic [31:0]   got_addr [$];
    logic [7:0]    got_len  [$];
    logic [DW-1:0] got_data [$];

    task automatic clear_log();
        got_addr.delete();
        got_len.delete();
        got_data.delete();
        src_val     = 0;
        beat_cnt    = 0;
        b_idx       = 0;
        overlap     = 0;
        wlast_err   = 0;
        err_seen    = -1;
        err_dropped = 0;
        cur_len     = 0;
        b_pending   = 1'b0;
    endtask

    // Drive this cycle's inputs, then log the handshakes the next rising edge completes.
    task automatic drive_step();
        awready  = (int'($urandom_range(99)) >= aw_stall);
        wready   = (int'($urandom_range(99)) >= w_stall);
        bvalid   = b_pending && (int'($urandom_range(99)) >= b_stall);
        bresp    = (b_idx == err_burst) ? 2'b10 : 2'b00;
        in_valid = (src_val < TOTAL) && (int'($urandom_range(99)) < in_pct);
        in_data  = DW'(src_val);

        if (awvalid && wvalid) overlap++;
        if (write_error && err_seen < 0) err_seen = b_idx;
        if (err_seen >= 0 && !write_error) err_dropped++;
        if (awvalid && awready) begin
            got_addr.push_back(awaddr);
            got_len.push_back(awlen);
            cur_len = int'(awlen);
        end
        if (wvalid && wready) begin
            got_data.push_back(wdata);
            if (wlast !== (beat_cnt == cur_len)) wlast_err++;
            if (wlast) begin
                beat_cnt  = 0;
                b_pending = 1'b1;
            end else begin
                beat_cnt++;
            end
        end
        if (bvalid && bready) begin
            b_pending = 1'b0;
            b_idx++;
        end
        if (in_valid && in_ready) src_val++;
    endtask

    task automatic cycle();
        @(negedge clk);
        write_start = 1'b0;
        drive_step();
    endtask

    task automatic start_run(input logic [31:0] base);
        clear_log();
        @(negedge clk);
        write_start  = 1'b1;
        awaddr_start = base;
        drive_step();
    endtask

    task automatic wait_done(input string name, input int budget, input bit pulse_mid);
        int n;
        cycle();
        n = 1;
        while (!write_done && n < budget) begin
            cycle();
            n++;
            if (pulse_mid && n == 100) begin
                write_start  = 1'b1;
                awaddr_start = 32'h00FF_F000;
            end
        end
        checks++;
        if (write_done !== 1'b1) begin
            failures++;
            $display("FAIL %s_done: write_done=%b after %0d cycles, required 1", name, write_done, n);
        end
    endtask

    task automatic check_run(input string name, input logic [31:0] base, input logic exp_err);
        int bad;
        checks++;
        if (got_addr.size() != NB) begin
            failures++;
            $display("FAIL %s_bursts: got %0d bursts, required %0d", name, got_addr.size(), NB);
        end
        bad = 0;
        foreach (got_addr[i]) begin
            if (got_addr[i] !== base + BURST_BYTES * i || got_len[i] !== 8'd15) begin
                if (bad == 0)
                    $display("FAIL %s_aw: burst %0d addr=%h len=%0d, required addr=%h len=15",
                             name, i, got_addr[i], got_len[i], base + BURST_BYTES * i);
                bad++;
            end
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (got_data.size() != TOTAL) begin
            failures++;
            $display("FAIL %s_beats: got %0d beats, required %0d", name, got_data.size(), TOTAL);
        end
        bad = 0;
        foreach (got_data[i]) begin
            if (got_data[i] !== DW'(i)) begin
                if (bad == 0)
                    $display("FAIL %s_data: beat %0d = %0d, required %0d", name, i, got_data[i][31:0], i);
                bad++;
            end
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("FAIL %s_aw_w_overlap: %0d cycles with awvalid&&wvalid, required 0", name, overlap);
        end
        checks++;
        if (wlast_err != 0) begin
            failures++;
            $display("FAIL %s_wlast: %0d misplaced wlast beats, required 0", name, wlast_err);
        end
        checks++;
        if (write_error !== exp_err) begin
            failures++;
            $display("FAIL %s_error: write_error=%b, required %b", name, write_error, exp_err);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({awvalid, wvalid, wlast, bready, in_ready, write_done, write_error} !== 7'b0) begin
            failures++;
            $display("FAIL %s_ctrl: aw/w/last/b/in_rdy/done/err=%b, required 0000000", name,
                     {awvalid, wvalid, wlast, bready, in_ready, write_done, write_error});
        end
        checks++;
        if (awaddr !== 32'd0 || awlen !== 8'd0) begin
            failures++;
            $display("FAIL %s_aw: awaddr=%h awlen=%0d, required 0/0", name, awaddr, awlen);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        write_start = 1'b0; awaddr_start = '0; in_data = '0; in_valid = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        s_write_start = 1'b0; s_awaddr_start = '0; s_in_data = '0; s_in_valid = 1'b0;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        checks++;
        if (awsize !== 3'd5 || awburst !== 2'b01) begin
            failures++;
            $display("FAIL reset_size_burst: awsize=%0d awburst=%b, required 5/01", awsize, awburst);
        end
        checks++;
        if ({s_in_ready, s_write_done, s_awvalid, s_wvalid} !== 4'b0) begin
            failures++;
            $display("FAIL reset_small: in_rdy/done/awv/wv=%b, required 0000",
                     {s_in_ready, s_write_done, s_awvalid, s_wvalid});
        end
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        aw_stall = 0; w_stall = 0; b_stall = 0; in_pct = 100; err_burst = -1;
        start_run(32'h0);
        wait_done("full", 5000, 1'b0);
        check_run("full", 32'h0, 1'b0);
    endtask

    task automatic test_error();
        aw_stall = 0; w_stall = 0; b_stall = 0; in_pct = 100; err_burst = 3;
        start_run(32'h0000_2000);
        wait_done("err", 5000, 1'b0);
        check_run("err", 32'h0000_2000, 1'b1);
        checks++;
        if (err_seen != 4) begin
            failures++;
            $display("FAIL err_first: error first seen after %0d responses, required 4", err_seen);
        end
        checks++;
        if (err_dropped != 0) begin
            failures++;
            $display("FAIL err_sticky: error dropped for %0d cycles, required 0", err_dropped);
        end
    endtask

    task automatic test_random_stalls();
        aw_stall = 40; w_stall = 40; b_stall = 50; in_pct = 50; err_burst = -1;
        start_run(32'h0001_0000);
        wait_done("stall", 20000, 1'b1);
        check_run("stall", 32'h0001_0000, 1'b0);
    endtask

    task automatic test_partial();
        logic [31:0] a [$];
        logic [7:0]  l [$];
        int          lastb [$];
        int          beats = 0;
        int          src = 0;
        int          n = 0;
        bit          pend = 1'b0;
        @(negedge clk);
        s_write_start  = 1'b1;
        s_awaddr_start = 32'h0;
        while (n < 2000) begin
            s_awready  = 1'b1;
            s_wready   = 1'b1;
            s_bvalid   = pend;
            s_bresp    = 2'b00;
            s_in_valid = (src < 20);
            s_in_data  = DW'(src);
            if (s_awvalid && s_awready) begin
                a.push_back(s_awaddr);
                l.push_back(s_awlen);
            end
            if (s_wvalid && s_wready) begin
                beats++;
                if (s_wlast) begin
                    lastb.push_back(beats);
                    pend = 1'b1;
                end
            end
            if (s_bvalid && s_bready) pend = 1'b0;
            if (s_in_valid && s_in_ready) src++;
            @(negedge clk);
            s_write_start = 1'b0;
            n++;
            if (s_write_done) break;
        end
        checks++;
        if (s_write_done !== 1'b1) begin
            failures++;
            $display("FAIL partial_done: write_done=%b, required 1", s_write_done);
        end
        checks++;
        if (a.size() != 2) begin
            failures++;
            $display("FAIL partial_bursts: got %0d bursts, required 2", a.size());
        end else begin
            checks++;
            if (a[0] !== 32'h0 || l[0] !== 8'd15) begin
                failures++;
                $display("FAIL partial_b0: addr=%h len=%0d, required 0/15", a[0], l[0]);
            end
            checks++;
            if (a[1] !== 32'h200 || l[1] !== 8'd3) begin
                failures++;
                $display("FAIL partial_b1: addr=%h len=%0d, required 200/3", a[1], l[1]);
            end
        end
        checks++;
        if (lastb.size() != 2 || lastb[0] != 16 || lastb[1] != 20) begin
            failures++;
            $display("FAIL partial_wlast: %0d wlast beats (first %0d), required beats 16 and 20",
                     lastb.size(), (lastb.size() > 0) ? lastb[0] : -1);
        end
        checks++;
        if (beats != 20) begin
            failures++;
            $display("FAIL partial_beats: got %0d beats, required 20", beats);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        aw_stall = 0; w_stall = 0; b_stall = 0; in_pct = 100; err_burst = -1;
        start_run(32'h0);
        while (!(got_data.size() >= 20 && wvalid) && n < 2000) begin
            cycle();
            n++;
        end
        checks++;
        if (!(got_data.size() >= 20 && wvalid)) begin
            failures++;
            $display("FAIL rstmid_reach: %0d beats before timeout, required mid-burst state", got_data.size());
        end
        @(negedge clk);
        rst = 1'b1;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("rstmid");
        rst = 1'b0;
        start_run(32'h0);
        wait_done("rerun", 5000, 1'b0);
        check_run("rerun", 32'h0, 1'b0);
    endtask

    initial begin
        clear_log();
        aw_stall = 0; w_stall = 0; b_stall = 0; in_pct = 100; err_burst = -1;
        test_reset();
        test_full_run();
        test_error();
        test_random_stalls();
        test_partial();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_package_writer.md
AXI_PACKAGE_WRITER -- requirements
Module: axi_package_writer

Interface
REQ-001 SHALL have parameter TOTAL_PACKAGE, default 400: beats written per run.
REQ-002 SHALL have parameter DATA_DEPTH, default 16: max burst length in beats, and FIFO depth.
REQ-003 SHALL have parameter DATA_BYTE_SHIFT, default 5: log2 of bytes per beat.
REQ-004 SHALL have parameter DATA_BYTE_WIDTH, default 32: bytes per beat; data width DW = DATA_BYTE_WIDTH*8.
REQ-005 SHALL have port clk  in  1  sole clock.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port write_start  in  1  one-cycle pulse that starts a run.
REQ-008 SHALL have port axi_awaddr_start  in  32  run base byte address, sampled on write_start.
REQ-009 SHALL have port in_data  in  DW  package beat.
REQ-010 SHALL have port in_valid  in  1  in_data valid.
REQ-011 SHALL have port in_ready  out  1  beat accepted when in_valid&&in_ready.
REQ-012 SHALL have port axi_awaddr  out  32  burst start address.
REQ-013 SHALL have port axi_awlen  out  8  burst beats minus 1.
REQ-014 SHALL have port axi_awsize  out  3  constant DATA_BYTE_SHIFT.
REQ-015 SHALL have port axi_awburst  out  2  constant 2'b01 (INCR).
REQ-016 SHALL have port axi_awvalid / axi_awready  out / in  1  AW handshake.
REQ-017 SHALL have port axi_wdata  out  DW  write data, from FIFO head.
REQ-018 SHALL have port axi_wlast / axi_wvalid / axi_wready  out / out / in  1  W handshake.
REQ-019 SHALL have port axi_bresp  in  2  write response.
REQ-020 SHALL have port axi_bvalid / axi_bready  in / out  1  B handshake.
REQ-021 SHALL have ports write_done and write_error  out  1 each: run complete; sticky non-OKAY response seen. AWID, WSTRB (all ones) and BID are tied or ignored at the integrating top.

Function
REQ-022 FSM SHALL be IDLE -> FILL -> ADDR -> DATA -> RESP -> (FILL if beats remain, else DONE); DONE -> FILL on next write_start.
REQ-023 write_start outside IDLE/DONE SHALL be ignored. On write_start: remaining=TOTAL_PACKAGE, addr=axi_awaddr_start, write_done=0, write_error=0.
REQ-024 in_ready SHALL equal FIFO not full while a run is active (state not IDLE/DONE), else 0. A FIFO accept while full SHALL never occur.
REQ-025 FILL SHALL exit when FIFO count >= min(remaining, DATA_DEPTH); burst length L = that min; axi_awlen = L-1.
REQ-026 ADDR SHALL hold axi_awvalid=1 with stable axi_awaddr/awlen until axi_awready; awvalid and wvalid are never asserted together.
REQ-027 DATA SHALL assert axi_wvalid while FIFO nonempty; pop on wvalid&&wready; axi_wlast=1 on beat L only; exit after the wlast handshake.
REQ-028 RESP SHALL hold axi_bready=1 until axi_bvalid; bresp!=2'b00 sets write_error (sticky); then addr += L<<DATA_BYTE_SHIFT, remaining -= L.
REQ-029 The FIFO SHALL keep accepting input during ADDR/DATA/RESP; a simultaneous push and pop keeps count unchanged.
REQ-030 remaining reaching 0 SHALL enter DONE with write_done=1 held until the next write_start or rst; the partial final burst uses L=TOTAL_PACKAGE mod DATA_DEPTH.
REQ-031 axi_awaddr_start SHALL be DATA_DEPTH<<DATA_BYTE_SHIFT aligned (bursts never cross 4 KB); no burst splitting.

Reset
REQ-032 On rst: state IDLE, FIFO emptied, awvalid=wvalid=wlast=bready=in_ready=0, write_done=write_error=0, axi_awaddr=0, axi_awlen=0; rst mid-burst SHALL abandon the burst with no further handshakes.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding, AXI_BURST_INCR and AXI_RESP_OKAY constants.
REQ-034 Buffering SHALL be one sub-module, sync_fifo (DW wide, DATA_DEPTH deep, count output, first-word-fall-through).

Verification
REQ-035 TOTAL_PACKAGE=400, 0 base, awready/wready/bvalid always ready -> 25 bursts, awlen=15, addresses 0,512,...,12288, write_done=1.
REQ-036 TOTAL_PACKAGE=20 -> bursts awlen=15 at 0x0 and awlen=3 at 0x200; wlast on beats 16 and 20 only.
REQ-037 Random wready/awready/bvalid stalls, in_valid 50% -> data at the BRAM side equals input sequence 0..399, no beat lost or duplicated.
REQ-038 bresp=2'b10 on burst 3 -> write_error=1 persists, run still completes with write_done=1.
REQ-039 rst asserted mid-DATA -> next cycle all outputs at reset values; a new write_start yields a clean run from burst 0.
